// File: rtl/kp_pkg.sv
// Shared definitions for the keypoint collector: scale codes, coordinate and FIFO entry field widths.
// The response field is appended to each FIFO entry only when KP_RESPONSE_EN is defined.
package kp_pkg;

  localparam int KP_COORD_W    = 10;
  localparam int KP_SCALE_W    = 3;
  localparam int KP_NUM_SCALES = 6;
  localparam int KP_META_W     = 2 * KP_COORD_W + KP_SCALE_W;

  typedef enum logic [KP_SCALE_W-1:0] {
    SCALE_15 = 3'd0,
    SCALE_21 = 3'd1,
    SCALE_27 = 3'd2,
    SCALE_33 = 3'd3,
    SCALE_39 = 3'd4,
    SCALE_45 = 3'd5
  } kp_scale_e;

endpackage

// File: rtl/kp_fifo.sv
// Synchronous keypoint FIFO with full/empty flags.
// When full, a write is still taken if a read happens in the same cycle.
module kp_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/keypoint_collector.sv
// Collects per-scale NMS maxima into keypoints (best flagged scale), queues them, and counts per frame.
// Define KP_RESPONSE_EN to carry the winning response through the FIFO onto kp_response.
module keypoint_collector
  import kp_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int FIFO_DEPTH   = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         din_valid,
  input  logic                         max_flag_scale_15,
  input  logic                         max_flag_scale_21,
  input  logic                         max_flag_scale_27,
  input  logic                         max_flag_scale_33,
  input  logic                         max_flag_scale_39,
  input  logic                         max_flag_scale_45,
  input  logic signed [DATA_WIDTH-1:0] max_response15,
  input  logic signed [DATA_WIDTH-1:0] max_response21,
  input  logic signed [DATA_WIDTH-1:0] max_response27,
  input  logic signed [DATA_WIDTH-1:0] max_response33,
  input  logic signed [DATA_WIDTH-1:0] max_response39,
  input  logic signed [DATA_WIDTH-1:0] max_response45,
  input  logic [KP_COORD_W-1:0]        x,
  input  logic [KP_COORD_W-1:0]        y,
  output logic                         kp_valid,
  input  logic                         kp_ready,
  output logic [KP_COORD_W-1:0]        kp_x,
  output logic [KP_COORD_W-1:0]        kp_y,
  output logic [KP_SCALE_W-1:0]        kp_scale,
  output logic [DATA_WIDTH-1:0]        kp_response,
  output logic                         frame_done,
  output logic [15:0]                  frame_kp_count,
  output logic                         overflow,
  output logic [15:0]                  drop_count
);

`ifdef KP_RESPONSE_EN
  localparam int ENTRY_W = KP_META_W + DATA_WIDTH;
`else
  localparam int ENTRY_W = KP_META_W;
`endif

  typedef struct packed {
    logic                         vld;
    logic [KP_SCALE_W-1:0]        code;
    logic signed [DATA_WIDTH-1:0] resp;
  } cand_t;

  // Operand a always carries the lower scale codes, so >= resolves ties toward the lower code.
  function automatic cand_t pick(input cand_t a, input cand_t b);
    if (!b.vld) return a;
    if (!a.vld) return b;
    return ($signed(a.resp) >= $signed(b.resp)) ? a : b;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  cand_t                 cand_in [KP_NUM_SCALES];
  logic                  cand_beat;
  logic                  eof_beat;

  assign cand_in[0] = {max_flag_scale_15, SCALE_15, max_response15};
  assign cand_in[1] = {max_flag_scale_21, SCALE_21, max_response21};
  assign cand_in[2] = {max_flag_scale_27, SCALE_27, max_response27};
  assign cand_in[3] = {max_flag_scale_33, SCALE_33, max_response33};
  assign cand_in[4] = {max_flag_scale_39, SCALE_39, max_response39};
  assign cand_in[5] = {max_flag_scale_45, SCALE_45, max_response45};

  assign cand_beat = din_valid & (max_flag_scale_15 | max_flag_scale_21 | max_flag_scale_27 |
                                  max_flag_scale_33 | max_flag_scale_39 | max_flag_scale_45);
  assign eof_beat  = din_valid && (x == KP_COORD_W'(IMAGE_WIDTH - 1))
                               && (y == KP_COORD_W'(IMAGE_HEIGHT - 1));

  // Stage 1: three pairwise compares
  cand_t                 pair_p1 [3];
  logic [KP_COORD_W-1:0] x_p1;
  logic [KP_COORD_W-1:0] y_p1;
  logic                  vld_p1;
  logic                  eof_p1;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) pair_p1[i] <= pick(cand_in[2*i], cand_in[2*i+1]);
    x_p1 <= x;
    y_p1 <= y;
  end

  // Stage 2: final compare, result feeds the FIFO write slot
  cand_t                 win_c;
  logic [KP_SCALE_W-1:0] code_p2;
  logic [KP_COORD_W-1:0] x_p2;
  logic [KP_COORD_W-1:0] y_p2;
  logic                  vld_p2;
  logic                  eof_p2;

  assign win_c = pick(pick(pair_p1[0], pair_p1[1]), pair_p1[2]);

`ifdef KP_RESPONSE_EN
  logic [DATA_WIDTH-1:0] resp_p2;
  always_ff @(posedge clk) resp_p2 <= win_c.resp;
`else
  logic resp_unused;
  assign resp_unused = ^win_c.resp;
`endif

  always_ff @(posedge clk) begin
    code_p2 <= win_c.code;
    x_p2    <= x_p1;
    y_p2    <= y_p1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      eof_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      eof_p2 <= 1'b0;
    end else begin
      vld_p1 <= cand_beat;
      eof_p1 <= eof_beat;
      vld_p2 <= vld_p1 & win_c.vld;
      eof_p2 <= eof_p1;
    end
  end

  // FIFO write / read and output presentation
  logic [ENTRY_W-1:0] fifo_wr_data;
  logic [ENTRY_W-1:0] fifo_rd_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic               rd_en;
  logic               accept;
  logic               drop;

`ifdef KP_RESPONSE_EN
  assign fifo_wr_data = {x_p2, y_p2, code_p2, resp_p2};
`else
  assign fifo_wr_data = {x_p2, y_p2, code_p2};
`endif

  assign rd_en  = kp_valid & kp_ready;
  assign accept = vld_p2 & (~fifo_full | rd_en);
  assign drop   = vld_p2 & fifo_full & ~rd_en;

  kp_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (vld_p2),
    .wr_data (fifo_wr_data),
    .rd_en   (rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Unread FIFO slots hold stale data, so the head is masked to zero while empty.
  assign kp_valid = ~fifo_empty;
  assign kp_x     = kp_valid ? fifo_rd_data[ENTRY_W-1 -: KP_COORD_W] : '0;
  assign kp_y     = kp_valid ? fifo_rd_data[ENTRY_W-KP_COORD_W-1 -: KP_COORD_W] : '0;
  assign kp_scale = kp_valid ? fifo_rd_data[ENTRY_W-2*KP_COORD_W-1 -: KP_SCALE_W] : '0;
`ifdef KP_RESPONSE_EN
  assign kp_response = kp_valid ? fifo_rd_data[DATA_WIDTH-1:0] : '0;
`else
  assign kp_response = '0;
`endif

  assign frame_done = eof_p2;

  // Frame statistics; overflow history survives frame boundaries
  logic [15:0] frame_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt      <= '0;
      frame_kp_count <= '0;
      drop_count     <= '0;
      overflow       <= 1'b0;
    end else begin
      if (eof_p2) begin
        frame_kp_count <= accept ? sat_inc16(frame_cnt) : frame_cnt;
        frame_cnt      <= '0;
      end else if (accept) begin
        frame_cnt <= sat_inc16(frame_cnt);
      end
      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= sat_inc16(drop_count);
      end
    end
  end

endmodule

// File: tb/tb_keypoint_collector.sv
// Scoreboard bench for keypoint_collector: directed scenarios plus a randomized phase against a reference model.
// Expected response values follow KP_RESPONSE_EN in the same way as the design.
module tb_keypoint_collector;

  localparam int DW    = 32;
  localparam int IW    = 640;
  localparam int IH    = 480;
  localparam int DEPTH = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 din_valid;
  logic [5:0]           flag_v;
  logic signed [DW-1:0] resp_v [6];
  logic [9:0]           x_v;
  logic [9:0]           y_v;
  logic                 kp_valid;
  logic                 kp_ready;
  logic [9:0]           kp_x;
  logic [9:0]           kp_y;
  logic [2:0]           kp_scale;
  logic [DW-1:0]        kp_response;
  logic                 frame_done;
  logic [15:0]          frame_kp_count;
  logic                 overflow;
  logic [15:0]          drop_count;

  always #5 clk = ~clk;

  keypoint_collector #(
    .DATA_WIDTH   (DW),
    .IMAGE_WIDTH  (IW),
    .IMAGE_HEIGHT (IH),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .din_valid         (din_valid),
    .max_flag_scale_15 (flag_v[0]),
    .max_flag_scale_21 (flag_v[1]),
    .max_flag_scale_27 (flag_v[2]),
    .max_flag_scale_33 (flag_v[3]),
    .max_flag_scale_39 (flag_v[4]),
    .max_flag_scale_45 (flag_v[5]),
    .max_response15    (resp_v[0]),
    .max_response21    (resp_v[1]),
    .max_response27    (resp_v[2]),
    .max_response33    (resp_v[3]),
    .max_response39    (resp_v[4]),
    .max_response45    (resp_v[5]),
    .x                 (x_v),
    .y                 (y_v),
    .kp_valid          (kp_valid),
    .kp_ready          (kp_ready),
    .kp_x              (kp_x),
    .kp_y              (kp_y),
    .kp_scale          (kp_scale),
    .kp_response       (kp_response),
    .frame_done        (frame_done),
    .frame_kp_count    (frame_kp_count),
    .overflow          (overflow),
    .drop_count        (drop_count)
  );

  typedef struct {
    logic [9:0]    x;
    logic [9:0]    y;
    logic [2:0]    s;
    logic [DW-1:0] r;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   model_cnt = 0;
  int   model_drop = 0;
  int   fd_count  = 0;
  bit   full_rule = 1'b0;
  bit   rand_ready = 1'b0;
  bit   held_v = 1'b0;
  logic [54:0] held;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: best signed response among flagged scales, first (lowest) code wins ties.
  function automatic exp_t ref_kp(input logic [9:0] bx, input logic [9:0] by, input logic [5:0] fl);
    int   best;
    exp_t e;
    best = -1;
    for (int i = 0; i < 6; i++)
      if (fl[i] && (best < 0 || resp_v[i] > resp_v[best])) best = i;
    e.x = bx;
    e.y = by;
    e.s = 3'(best);
`ifdef KP_RESPONSE_EN
    e.r = resp_v[best];
`else
    e.r = '0;
`endif
    return e;
  endfunction

  task automatic rand_resp();
    int t;
    for (int i = 0; i < 6; i++) begin
      t = int'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) resp_v[i] = $urandom;
      else resp_v[i] = (t - 4) * 256;
    end
  endtask

  task automatic issue(input logic [9:0] bx, input logic [9:0] by, input logic [5:0] fl,
                       input bit vld = 1'b1);
    din_valid = vld;
    x_v       = bx;
    y_v       = by;
    flag_v    = fl;
    if (rand_ready) kp_ready = ($urandom_range(0, 3) != 0);
    if (vld && fl != 6'd0) begin
      if (full_rule && exp_q.size() >= DEPTH) model_drop++;
      else begin
        exp_q.push_back(ref_kp(bx, by, fl));
        model_cnt++;
      end
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    flag_v    = 6'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    kp_ready = 1'b1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    idle(4);
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_kp_valid", {63'd0, kp_valid}, 64'd0);
  endtask

  // Monitor: pops the scoreboard on every transfer and checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v)
        chk("hold_stable", {8'd0, kp_valid, kp_x, kp_y, kp_scale, kp_response}, {8'd0, 1'b1, held});
      if (kp_valid && kp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_kp", {9'd0, kp_x, kp_y, kp_scale, kp_response}, 64'hDEAD_0000_0000_0000);
        end else begin
          mon_e = exp_q.pop_front();
          chk("kp_word", {9'd0, kp_x, kp_y, kp_scale, kp_response},
              {9'd0, mon_e.x, mon_e.y, mon_e.s, mon_e.r});
        end
      end
      held_v = kp_valid && !kp_ready;
      held   = {kp_x, kp_y, kp_scale, kp_response};
      if (frame_done) fd_count++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] xs [5];
    logic [9:0] ys [5];
    xs = '{10'd10, 10'd320, 10'd0, 10'd600, 10'd639};
    ys = '{10'd0, 10'd100, 10'd240, 10'd400, 10'd479};

    rst = 1'b1; din_valid = 1'b0; flag_v = '0; x_v = '0; y_v = '0; kp_ready = 1'b0;
    for (int i = 0; i < 6; i++) resp_v[i] = '0;
    idle(3);
    chk("rst_kp_valid", {63'd0, kp_valid}, 64'd0);
    chk("rst_kp_fields", {9'd0, kp_x, kp_y, kp_scale, kp_response}, 64'd0);
    chk("rst_counters", {31'd0, frame_kp_count, drop_count, overflow}, 64'd0);
    chk("rst_frame_done", {63'd0, frame_done}, 64'd0);
    rst = 1'b0;
    idle(1);
    chk("post_rst_kp_valid", {63'd0, kp_valid}, 64'd0);

    // Two flagged scales, larger response wins; 3-cycle first-word latency
    kp_ready = 1'b1;
    resp_v[1] = 32'h500; resp_v[3] = 32'h700;
    issue(10'd100, 10'd50, 6'b001010);
    chk("lat_cycle1", {63'd0, kp_valid}, 64'd0);
    idle(1);
    chk("lat_cycle2", {63'd0, kp_valid}, 64'd0);
    idle(1);
    chk("lat_cycle3", {63'd0, kp_valid}, 64'd1);
    chk("lat_word", {41'd0, kp_x, kp_y, kp_scale}, {41'd0, 10'd100, 10'd50, 3'd3});
    drain();

    // Tie between lowest and highest scale goes to code 0
    for (int i = 0; i < 6; i++) resp_v[i] = '0;
    resp_v[0] = 32'h300; resp_v[5] = 32'h300;
    issue(10'd200, 10'd60, 6'b100001);
    // Unflagged large response is ignored; negatives compare signed
    resp_v[0] = 32'h7FFF_FFFF; resp_v[2] = -5; resp_v[4] = -3;
    issue(10'd201, 10'd60, 6'b010100);
    issue(10'd202, 10'd60, 6'b000000);
    issue(10'd203, 10'd60, 6'b111111, 1'b0);
    drain();

    // Overflow: DEPTH+3 candidates with no reads
    kp_ready = 1'b0; full_rule = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      rand_resp();
      issue(10'(i), 10'd1, 6'($urandom_range(1, 63)));
    end
    idle(3);
    chk("ovf_drop_count", {48'd0, drop_count}, 64'(model_drop));
    chk("ovf_flag", {63'd0, overflow}, 64'd1);
    chk("ovf_kp_valid", {63'd0, kp_valid}, 64'd1);
    full_rule = 1'b0;
    drain();
    chk("ovf_drop_after_drain", {48'd0, drop_count}, 64'd3);

    // Full FIFO with a read in the new word's write cycle: no drop
    kp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rand_resp();
      issue(10'(i), 10'd2, 6'($urandom_range(1, 63)));
    end
    rand_resp();
    issue(10'd500, 10'd2, 6'($urandom_range(1, 63)));
    idle(1);
    kp_ready = 1'b1;
    idle(1);
    kp_ready = 1'b0;
    idle(2);
    chk("simul_rw_no_drop", {48'd0, drop_count}, 64'd3);
    chk("simul_rw_valid", {63'd0, kp_valid}, 64'd1);
    drain();

    // Reset mid-frame with words queued and one in flight
    kp_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_resp();
      issue(10'(i), 10'd3, 6'($urandom_range(1, 63)));
    end
    idle(3);
    chk("pre_rst_valid", {63'd0, kp_valid}, 64'd1);
    issue(10'd20, 10'd3, 6'b000001);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", {63'd0, kp_valid}, 64'd0);
    idle(1);
    chk("rst_mid_valid", {63'd0, kp_valid}, 64'd0);
    chk("rst_mid_counters", {47'd0, drop_count, overflow}, 64'd0);
    exp_q.delete();
    model_cnt = 0; model_drop = 0;
    idle(1);
    rst = 1'b0;
    kp_ready = 1'b1;
    idle(5);
    chk("rst_inflight_discarded", {63'd0, kp_valid}, 64'd0);

    // Frame with 5 candidates, last one on the final pixel
    fd_count = 0;
    for (int k = 0; k < 4; k++) begin
      rand_resp();
      issue(xs[k], ys[k], 6'($urandom_range(1, 63)));
      issue(xs[k] + 10'd1, ys[k], 6'd0);
      idle(2);
    end
    issue(10'd639, 10'd479, 6'h3F, 1'b0);
    rand_resp();
    issue(xs[4], ys[4], 6'($urandom_range(1, 63)));
    chk("fd_not_early", {63'd0, frame_done}, 64'd0);
    idle(1);
    chk("fd_pulse", {63'd0, frame_done}, 64'd1);
    idle(1);
    chk("fd_deassert", {63'd0, frame_done}, 64'd0);
    chk("frame_kp_count", {48'd0, frame_kp_count}, 64'd5);
    idle(3);
    chk("fd_single_pulse", 64'(fd_count), 64'd1);
    model_cnt = 0;
    drain();

    // Randomized frame checked against the reference model
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      rand_resp();
      issue(10'($urandom_range(0, IW - 2)), 10'($urandom_range(0, IH - 1)),
            ($urandom_range(0, 1) != 0) ? 6'($urandom) : 6'd0,
            $urandom_range(0, 9) != 0);
    end
    rand_resp();
    issue(10'(IW - 1), 10'(IH - 1), 6'($urandom_range(1, 63)));
    rand_ready = 1'b0;
    kp_ready = 1'b1;
    idle(1);
    chk("rand_fd_pulse", {63'd0, frame_done}, 64'd1);
    idle(1);
    chk("rand_frame_kp_count", {48'd0, frame_kp_count}, 64'(model_cnt));
    drain();
    chk("rand_no_drops", {47'd0, drop_count, overflow}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypoint_collector.md
KEYPOINT_COLLECTOR -- requirements
Module: keypoint_collector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, response word width.
REQ-002 SHALL have parameter IMAGE_WIDTH, default 640, pixels per row.
REQ-003 SHALL have parameter IMAGE_HEIGHT, default 480, rows per frame.
REQ-004 SHALL have parameter FIFO_DEPTH, default 64, keypoint FIFO entries (power of 2, >=4).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port din_valid  input  1  NMS result beat valid.
REQ-008 SHALL have ports max_flag_scale_{15,21,27,33,39,45}  input  1 each  per-scale local-max flags.
REQ-009 SHALL have ports max_response{15,21,27,33,39,45}  input  DATA_WIDTH each  signed per-scale responses.
REQ-010 SHALL have ports x, y  input  10 each  beat column/row.
REQ-011 SHALL have port kp_valid  output  1  keypoint word available.
REQ-012 SHALL have port kp_ready  input  1  downstream accepts keypoint.
REQ-013 SHALL have ports kp_x, kp_y  output  10 each  keypoint coordinates.
REQ-014 SHALL have port kp_scale  output  3  scale code 0..5 = 15,21,27,33,39,45.
REQ-015 SHALL have port kp_response  output  DATA_WIDTH  winning response.
REQ-016 SHALL have port frame_done  output  1  one-cycle end-of-frame pulse.
REQ-017 SHALL have port frame_kp_count  output  16  keypoints accepted in last completed frame.
REQ-018 SHALL have ports overflow  output  1  sticky drop flag; drop_count  output  16  saturating dropped-keypoint count.

Function
REQ-019 SHALL treat an input beat as a candidate when din_valid=1 and any max_flag_scale_* =1; non-candidate beats produce no keypoint.
REQ-020 SHALL select, among flagged scales only, the largest signed response; ties go to the lowest scale code.
REQ-021 SHALL use a 2-stage registered selection pipeline (stage 1: three pairwise compares, stage 2: final compare); FIFO write occurs 2 cycles after the input beat.
REQ-022 SHALL accept one beat per cycle with no backpressure on input.
REQ-023 SHALL write {x, y, scale, response} into the FIFO when not full, or when full and a read occurs in the same cycle.
REQ-024 SHALL otherwise drop the keypoint, set overflow, and increment drop_count, saturating at 16'hFFFF.
REQ-025 SHALL present the FIFO head on kp_* with kp_valid=1 whenever the FIFO is non-empty; transfer occurs when kp_valid & kp_ready.
REQ-026 SHALL hold kp_* stable while kp_valid=1 and kp_ready=0.
REQ-027 SHALL produce first-word latency of 3 cycles, input beat to kp_valid, when the FIFO is empty.
REQ-028 SHALL count accepted keypoints per frame in a 16-bit saturating counter.
REQ-029 SHALL detect end of frame on a din_valid beat with x=IMAGE_WIDTH-1 and y=IMAGE_HEIGHT-1.
REQ-030 SHALL pulse frame_done 2 cycles after that beat, aligned with its write slot.
REQ-031 SHALL, in the frame_done cycle, load frame_kp_count including that last beat's keypoint, and clear the running counter.
REQ-032 SHALL NOT clear overflow or drop_count at frame_done; only rst clears them.

Reset
REQ-033 SHALL asynchronously clear on rst: pipeline valids, FIFO pointers, counters, overflow, and frame_done.
REQ-034 SHALL drive kp_valid=0, kp_x=0, kp_y=0, kp_scale=0, kp_response=0, frame_kp_count=0, and drop_count=0 during and after reset.
REQ-035 SHALL discard any in-flight or queued keypoints when rst is asserted mid-frame.

Configuration
REQ-036 SHALL, when KP_RESPONSE_EN is defined, store the response in the FIFO and drive kp_response.
REQ-037 SHALL, without KP_RESPONSE_EN, omit response storage from the FIFO, tie kp_response to 0, and keep scale selection unchanged.

Structure
REQ-038 SHALL define scale codes, KP_COORD_W=10, and the FIFO entry field widths in package kp_pkg.
REQ-039 SHALL implement the FIFO as sub-module kp_fifo: synchronous, FIFO_DEPTH deep, full/empty flags, same-cycle read+write when full.

Verification
REQ-040 Bench SHALL drive a beat at (100,50) with flags 21 and 33 set, responses 0x500 and 0x700 -> one keypoint (100,50), scale 3, response 0x700, kp_valid 3 cycles later.
REQ-041 Bench SHALL drive a beat with flags 15 and 45 set, both responses 0x300 -> scale 0.
REQ-042 Bench SHALL hold kp_ready=0 and send FIFO_DEPTH+3 candidates -> 64 stored, drop_count=3, overflow=1; on release, 64 words drain in order.
REQ-043 Bench SHALL fill the FIFO, then on the next candidate assert kp_ready=1 in its write cycle -> no drop.
REQ-044 Bench SHALL run a full 640x480 frame with 5 candidates, the last at (639,479) -> frame_done pulses once, frame_kp_count=5.
REQ-045 Bench SHALL assert rst mid-frame with 10 words queued -> kp_valid=0 next edge; the next frame's count excludes pre-reset keypoints.
